// File: rtl/servo_pwm_bank.sv
// ---------------------------------------------------------------------------
// servo_pwm_bank
//
// Multi-channel servo PWM generator. All channels share one prescaler and one
// period counter. Each channel's pulse lasts MIN_PULSE + active duty ticks.
// Duty values arrive through a valid/ready write port into per-channel shadow
// registers. Shadows are copied to the active registers only at the period
// boundary, so a pulse is never cut short or stretched mid-period. An
// optional slew limit bounds how far an active duty may move per period.
//
// Ports
//   i_clockdiv      system clock, rising edge
//   i_reset         synchronous, active-high reset
//   i_enable        1 = run counters, 0 = hold counters at 0 and outputs low
//   i_prescale      a tick occurs every i_prescale+1 clocks
//   i_endcount      terminal count, period = i_endcount+1 ticks
//   i_wr_valid      duty write request
//   o_wr_ready      write accepted when i_wr_valid & o_wr_ready
//   i_wr_ch         target channel of the write
//   i_wr_duty       new duty value
//   o_wr_err        one-clock pulse after an accepted write to a bad channel
//   o_pending       per channel: shadow differs from active
//   o_period_start  one-clock pulse while the counter sits at 0 after a wrap
//   o_pwm_out       registered PWM outputs
// ---------------------------------------------------------------------------
module servo_pwm_bank #(
    parameter int NCH       = 4,
    parameter int CNT_W     = 12,
    parameter int DUTY_W    = 8,
    parameter int PRE_W     = 8,
    parameter int MIN_PULSE = 64,
    parameter int SLEW_STEP = 0,
    localparam int CH_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              i_clockdiv,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic [PRE_W-1:0]  i_prescale,
    input  logic [CNT_W-1:0]  i_endcount,
    input  logic              i_wr_valid,
    output logic              o_wr_ready,
    input  logic [CH_W-1:0]   i_wr_ch,
    input  logic [DUTY_W-1:0] i_wr_duty,
    output logic              o_wr_err,
    output logic [NCH-1:0]    o_pending,
    output logic              o_period_start,
    output logic [NCH-1:0]    o_pwm_out
);

    // The pulse-length sum must never wrap, whichever of the two operand
    // widths is larger.
    localparam int               SUM_W = ((CNT_W > DUTY_W) ? CNT_W : DUTY_W) + 1;
    localparam logic [CH_W:0]    NCH_L = (CH_W + 1)'(NCH);
    localparam logic [SUM_W-1:0] MIN_L = SUM_W'(MIN_PULSE);

    logic [PRE_W-1:0]  r_pre_cnt;
    logic [CNT_W-1:0]  r_counter;
    logic [DUTY_W-1:0] r_shadow [NCH];
    logic [DUTY_W-1:0] r_active [NCH];
    logic [NCH-1:0]    r_pending;
    logic [NCH-1:0]    r_pwm;
    logic              r_period_start;
    logic              r_wr_err;

    logic              w_tick;
    logic              w_wrap;
    logic              w_accept;
    logic              w_ch_valid;
    logic [DUTY_W-1:0] w_shadow_next [NCH];
    logic [DUTY_W-1:0] w_active_next [NCH];
    logic [SUM_W-1:0]  w_sum [NCH];

    // Move the active duty toward its target, limited to SLEW_STEP per
    // period when a limit is configured.
    function automatic logic [DUTY_W-1:0] f_step(input logic [DUTY_W-1:0] a,
                                                 input logic [DUTY_W-1:0] s);
        logic [DUTY_W-1:0] diff;
        logic [DUTY_W-1:0] res;
        res = s;
        if (SLEW_STEP != 0) begin
            if (s > a) begin
                diff = s - a;
                if (int'(diff) > SLEW_STEP)
                    res = a + DUTY_W'(SLEW_STEP);
            end else begin
                diff = a - s;
                if (int'(diff) > SLEW_STEP)
                    res = a - DUTY_W'(SLEW_STEP);
            end
        end
        return res;
    endfunction

    // Writes can be taken in any cycle except while reset is held.
    assign o_wr_ready = ~i_reset;
    assign w_accept   = i_wr_valid & o_wr_ready;
    assign w_ch_valid = ({1'b0, i_wr_ch} < NCH_L);

    // A prescale lowered below the running pre_cnt still produces a tick,
    // and an endcount lowered below the counter wraps on the next tick.
    assign w_tick = i_enable & (r_pre_cnt >= i_prescale);
    assign w_wrap = w_tick & (r_counter >= i_endcount);

    // Next-state of shadow and active registers. The commit reads the old
    // shadow, so a write landing in the wrap cycle waits one more period.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            w_active_next[i] = r_active[i];
            if (w_wrap)
                w_active_next[i] = f_step(r_active[i], r_shadow[i]);
            w_shadow_next[i] = r_shadow[i];
            if (w_accept && w_ch_valid && (i_wr_ch == CH_W'(i)))
                w_shadow_next[i] = i_wr_duty;
            w_sum[i] = MIN_L + SUM_W'(r_active[i]);
        end
    end

    // Prescaler, period counter, commit and output registers.
    always_ff @(posedge i_clockdiv) begin
        if (i_reset) begin
            r_pre_cnt      <= '0;
            r_counter      <= '0;
            r_pending      <= '0;
            r_pwm          <= '0;
            r_period_start <= 1'b0;
            r_wr_err       <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else begin
            if (!i_enable) begin
                r_pre_cnt <= '0;
                r_counter <= '0;
            end else if (w_tick) begin
                r_pre_cnt <= '0;
                r_counter <= w_wrap ? '0 : r_counter + CNT_W'(1);
            end else begin
                r_pre_cnt <= r_pre_cnt + PRE_W'(1);
            end
            r_period_start <= w_wrap;
            r_wr_err       <= w_accept & ~w_ch_valid;
            for (int i = 0; i < NCH; i++) begin
                r_shadow[i]  <= w_shadow_next[i];
                r_active[i]  <= w_active_next[i];
                r_pending[i] <= (w_shadow_next[i] != w_active_next[i]);
                r_pwm[i]     <= i_enable & (SUM_W'(r_counter) < w_sum[i]);
            end
        end
    end

    assign o_pending      = r_pending;
    assign o_pwm_out      = r_pwm;
    assign o_period_start = r_period_start;
    assign o_wr_err       = r_wr_err;

endmodule
